// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-adder slice plus a carry flop, LSB first.
// Optional zero/negative flags (ports zf, nf) are enabled by defining SERIAL_ADDSUB_FLAGS_EN.
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             co,
`ifdef SERIAL_ADDSUB_FLAGS_EN
    output logic             zf,
    output logic             nf,
`endif
    output logic             ovf
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic           carry;
    logic [CW-1:0]  cnt;
    logic           s, c_out, last, load;

    assign s     = a_sh[0] ^ b_sh[0] ^ carry;
    assign c_out = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    assign last  = (state == RUN) && (cnt == CW'(WIDTH - 1));
    // A start is honoured in IDLE and also on the edge leaving DONE (back-to-back ops).
    assign load  = start && (state != RUN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = start ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_sh   <= '0;
            b_sh   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            result <= '0;
            co     <= 1'b0;
            ovf    <= 1'b0;
        end else if (load) begin
            a_sh  <= a;
            b_sh  <= b ^ {WIDTH{op}};
            carry <= op;
            cnt   <= '0;
        end else if (state == RUN) begin
            carry  <= c_out;
            result <= {s, result[WIDTH-1:1]};
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            cnt    <= cnt + CW'(1);
            if (last) begin
                co  <= c_out;
                ovf <= (a_sh[0] == b_sh[0]) && (s != a_sh[0]);
            end
        end
    end

`ifdef SERIAL_ADDSUB_FLAGS_EN
    logic any_one;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            any_one <= 1'b0;
            zf      <= 1'b0;
            nf      <= 1'b0;
        end else if (load) begin
            any_one <= 1'b0;
        end else if (state == RUN) begin
            any_one <= any_one | s;
            if (last) begin
                zf <= ~(any_one | s);
                nf <= s;
            end
        end
    end
`endif

endmodule

// File: tb/tb_serial_addsub.sv
// Directed self-checking bench for serial_addsub (WIDTH=8): vector table plus
// hand-written back-to-back, ignored-start and asynchronous-reset sequences.
module tb_serial_addsub;

    localparam int WIDTH = 8;

    logic             clk;
    logic             reset;
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a, b;
    logic             busy, done, co, ovf;
    logic [WIDTH-1:0] result;
`ifdef SERIAL_ADDSUB_FLAGS_EN
    logic             zf, nf;
`endif

    int checks   = 0;
    int failures = 0;

    serial_addsub #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .co     (co),
`ifdef SERIAL_ADDSUB_FLAGS_EN
        .zf     (zf),
        .nf     (nf),
`endif
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       co;
        logic       ovf;
        logic       zf;
        logic       nf;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Waits (bounded) for done; n = number of negedges until done seen, 99 on timeout.
    task automatic wait_done(output int n);
        n = 99;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic drive(input logic o, input logic [7:0] x, input logic [7:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
    endtask

    task automatic check_flags(input string name, input vec_t v);
        check({name, "_result"}, 32'(result), 32'(v.res));
        check({name, "_co"}, 32'(co), 32'(v.co));
        check({name, "_ovf"}, 32'(ovf), 32'(v.ovf));
`ifdef SERIAL_ADDSUB_FLAGS_EN
        check({name, "_zf"}, 32'(zf), 32'(v.zf));
        check({name, "_nf"}, 32'(nf), 32'(v.nf));
`endif
    endtask

    initial begin
        int   n;
        int   pulses;
        vec_t v;

        //            op    a      b      res    co    ovf   zf    nf
        vecs[0] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 8'h7F, 8'hFF, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0};

        reset = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        v = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        check_flags("rst", v);
        reset = 1'b0;

        // Table-driven single operations
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            drive(vecs[k].op, vecs[k].a, vecs[k].b);
            @(negedge clk);
            start = 1'b0;
            check($sformatf("v%0d_busy_after_start", k), 32'(busy), 32'd1);
            check($sformatf("v%0d_no_early_done", k), 32'(done), 32'd0);
            wait_done(n);
            check($sformatf("v%0d_latency", k), 32'(n), 32'(WIDTH));
            check_flags($sformatf("v%0d", k), vecs[k]);
            @(negedge clk);
            check($sformatf("v%0d_done_one_cycle", k), 32'(done), 32'd0);
            check($sformatf("v%0d_busy_clear", k), 32'(busy), 32'd0);
            check($sformatf("v%0d_result_held", k), 32'(result), 32'(vecs[k].res));
        end

        // Back-to-back: second start on the edge leaving DONE
        @(negedge clk);
        drive(1'b1, 8'h80, 8'h01);
        @(negedge clk);
        start = 1'b0;
        wait_done(n);
        check("b2b_first_latency", 32'(n), 32'(WIDTH));
        check_flags("b2b_first", vecs[3]);
        drive(1'b0, 8'h12, 8'h34);
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy_kept", 32'(busy), 32'd1);
        check("b2b_done_dropped", 32'(done), 32'd0);
        wait_done(n);
        check("b2b_second_latency", 32'(n), 32'(WIDTH));
        check_flags("b2b_second", vecs[4]);
        @(negedge clk);
        check("b2b_idle", 32'(busy), 32'd0);

        // Start while busy is ignored
        @(negedge clk);
        drive(1'b0, 8'h10, 8'h20);
        @(negedge clk);
        start  = 1'b0;
        pulses = 0;
        for (int i = 1; i <= 24; i++) begin
            if (i == 3) drive(1'b0, 8'hFF, 8'hFF);
            if (i == 4) start = 1'b0;
            @(negedge clk);
            if (done) pulses++;
        end
        check("ign_done_pulses", 32'(pulses), 32'd1);
        v = '{1'b0, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0};
        check_flags("ign", v);
        check("ign_idle", 32'(busy), 32'd0);

        // Asynchronous reset mid-RUN
        @(negedge clk);
        drive(1'b0, 8'h7F, 8'h01);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_run_busy", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        v = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        check_flags("arst", v);
        @(negedge clk);
        drive(1'b0, 8'h55, 8'h11);
        @(negedge clk);
        check("rst_start_busy", 32'(busy), 32'd0);
        start = 1'b0;
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("arst_no_done", 32'(pulses), 32'd0);
        drive(1'b0, 8'h12, 8'h34);
        @(negedge clk);
        start = 1'b0;
        wait_done(n);
        check("post_rst_latency", 32'(n), 32'(WIDTH));
        check_flags("post_rst", vecs[4]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
